// File: rtl/antirrebote_sensores.sv
// Two-channel synchronizer and debouncer for the active-low barrier sensors.
// Each channel: 2-FF synchronizer, then an ESTABLE/VERIFICANDO qualifier with a stability counter.
module antirrebote_sensores #(
  parameter int N_ESTABLE = 500000,
  parameter int CNT_W     = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_evt,
  output logic b_evt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_ESTABLE - 1);

  if (N_ESTABLE < 2 || (64'(1) << CNT_W) <= 64'(N_ESTABLE - 1)) begin : g_param_err
    $error("antirrebote_sensores: N_ESTABLE must be >= 2 and fit in CNT_W bits");
  end

  logic [1:0] raw_vec;
  logic [1:0] out_vec;
  logic [1:0] evt_vec;

  assign raw_vec = {b_raw, a_raw};
  assign a       = out_vec[0];
  assign b       = out_vec[1];
  assign a_evt   = evt_vec[0];
  assign b_evt   = evt_vec[1];

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_canal
    typedef enum logic {ESTABLE, VERIFICANDO} estado_t;

    estado_t          state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             s1_reg, s_reg;
    logic             out_reg, out_next;
    logic             evt_reg, evt_next;

    always_ff @(posedge clk) begin
      if (!reset) begin
        s1_reg    <= 1'b1;
        s_reg     <= 1'b1;
        state_reg <= ESTABLE;
        cnt_reg   <= '0;
        out_reg   <= 1'b1;
        evt_reg   <= 1'b0;
      end else begin
        s1_reg    <= raw_vec[gi];
        s_reg     <= s1_reg;
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        out_reg   <= out_next;
        evt_reg   <= evt_next;
      end
    end

    // A bounce back to the current output level discards the whole qualification run.
    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      out_next   = out_reg;
      evt_next   = 1'b0;
      case (state_reg)
        ESTABLE: begin
          cnt_next = '0;
          if (s_reg != out_reg) begin
            state_next = VERIFICANDO;
            cnt_next   = CNT_W'(1);
          end
        end
        VERIFICANDO: begin
          if (s_reg == out_reg) begin
            state_next = ESTABLE;
            cnt_next   = '0;
          end else if (cnt_reg == CNT_MAX) begin
            state_next = ESTABLE;
            cnt_next   = '0;
            out_next   = s_reg;
            evt_next   = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = ESTABLE;
          cnt_next   = '0;
        end
      endcase
    end

    assign out_vec[gi] = out_reg;
    assign evt_vec[gi] = evt_reg;
  end

endmodule

// File: tb/tb_antirrebote_sensores.sv
// Bench for antirrebote_sensores: per-cycle scoreboard against a run-length reference
// model, plus directed latency and pulse-count checks from the test scenarios.
module tb_antirrebote_sensores;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a_raw = 1'b1;
  logic b_raw = 1'b1;
  logic a, b, a_evt, b_evt;

  int checks = 0;
  int errors = 0;
  int ea_cnt = 0, eb_cnt = 0, eab_cnt = 0;
  logic [3:0] exp_q[$];

  antirrebote_sensores #(.N_ESTABLE(N), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .a_raw(a_raw), .b_raw(b_raw),
    .a(a), .b(b), .a_evt(a_evt), .b_evt(b_evt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference: a new level is taken once the synchronized input has differed from
  // the output for N consecutive samples.
  initial begin : model
    logic m_s1 [2];
    logic m_s  [2];
    logic m_out[2];
    logic m_evt[2];
    logic rv   [2];
    int   m_run[2];
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 1'b1; m_s[c] = 1'b1; m_out[c] = 1'b1; m_evt[c] = 1'b0; m_run[c] = 0;
    end
    forever begin
      @(posedge clk);
      rv[0] = a_raw;
      rv[1] = b_raw;
      for (int c = 0; c < 2; c++) begin
        if (!reset) begin
          m_s1[c] = 1'b1; m_s[c] = 1'b1; m_out[c] = 1'b1; m_evt[c] = 1'b0; m_run[c] = 0;
        end else begin
          m_evt[c] = 1'b0;
          if (m_s[c] != m_out[c]) begin
            m_run[c]++;
            if (m_run[c] == N) begin
              m_out[c] = m_s[c];
              m_evt[c] = 1'b1;
              m_run[c] = 0;
            end
          end else begin
            m_run[c] = 0;
          end
          m_s[c]  = m_s1[c];
          m_s1[c] = rv[c];
        end
      end
      exp_q.push_back({m_out[0], m_out[1], m_evt[0], m_evt[1]});
    end
  end

  initial begin : scoreboard
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("sb_a_b_aevt_bevt", {28'd0, a, b, a_evt, b_evt}, {28'd0, e});
      end
      if (a_evt) ea_cnt++;
      if (b_evt) eb_cnt++;
      if (a_evt && b_evt) eab_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Counts edges until the chosen output reaches lvl; bounded at 20 edges.
  task automatic wait_level(input bit is_a, input logic lvl, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (((is_a ? a : b) !== lvl) && n < 20);
  endtask

  initial begin : stim
    int n, ba, bb, bab;

    // Scenario 1: reset, then step a_raw low.
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(2);
    check_val("rst_a", a, 1);
    check_val("rst_b", b, 1);
    check_val("rst_aevt", a_evt, 0);
    check_val("rst_bevt", b_evt, 0);
    ba = ea_cnt; bb = eb_cnt;
    a_raw = 1'b0;
    wait_level(1'b1, 1'b0, n);
    check_val("s1_latency", n, 6);
    check_val("s1_evt_now", a_evt, 1);
    step(3);
    check_val("s1_aevt_count", ea_cnt - ba, 1);
    check_val("s1_bevt_count", eb_cnt - bb, 0);
    a_raw = 1'b1;
    step(12);
    $display("scenario 1 done: checks=%0d errors=%0d", checks, errors);

    // Scenario 2: bounce too short, then one just long enough.
    bb = eb_cnt;
    b_raw = 1'b0; step(3);
    b_raw = 1'b1; step(2);
    b_raw = 1'b0; step(3);
    b_raw = 1'b1; step(10);
    check_val("s2_b_held", b, 1);
    check_val("s2_bevt_none", eb_cnt - bb, 0);
    bb = eb_cnt;
    b_raw = 1'b0; step(4);
    b_raw = 1'b1;
    wait_level(1'b0, 1'b0, n);
    check_val("s2_latency", n + 4, 6);
    step(12);
    check_val("s2_bevt_count", eb_cnt - bb, 2);
    $display("scenario 2 done: checks=%0d errors=%0d", checks, errors);

    // Scenario 3: simultaneous step on both channels.
    bab = eab_cnt;
    a_raw = 1'b0; b_raw = 1'b0;
    wait_level(1'b1, 1'b0, n);
    check_val("s3_latency", n, 6);
    check_val("s3_b_with_a", b, 0);
    step(2);
    check_val("s3_joint_evt", eab_cnt - bab, 1);
    a_raw = 1'b1; b_raw = 1'b1;
    step(12);
    $display("scenario 3 done: checks=%0d errors=%0d", checks, errors);

    // Scenario 4: full entry sequence.
    ba = ea_cnt; bb = eb_cnt;
    a_raw = 1'b0; b_raw = 1'b1; step(10);
    a_raw = 1'b0; b_raw = 1'b0; step(10);
    a_raw = 1'b1; b_raw = 1'b0; step(10);
    a_raw = 1'b1; b_raw = 1'b1; step(12);
    check_val("s4_aevt_count", ea_cnt - ba, 2);
    check_val("s4_bevt_count", eb_cnt - bb, 2);
    $display("scenario 4 done: checks=%0d errors=%0d", checks, errors);

    // Scenario 5: reset pulse at edge 4 while qualifying.
    a_raw = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);
    check_val("s5_rst_a", a, 1);
    check_val("s5_rst_aevt", a_evt, 0);
    reset = 1'b1;
    wait_level(1'b1, 1'b0, n);
    check_val("s5_restart_latency", n, 6);
    a_raw = 1'b1;
    step(12);
    $display("scenario 5 done: checks=%0d errors=%0d", checks, errors);

    // Scenario 6: single-cycle glitch not aligned to the clock.
    ba = ea_cnt;
    @(posedge clk); #3 a_raw = 1'b0;
    @(posedge clk); #3 a_raw = 1'b1;
    step(10);
    check_val("s6_a_held", a, 1);
    check_val("s6_aevt_none", ea_cnt - ba, 0);
    $display("scenario 6 done: checks=%0d errors=%0d", checks, errors);

    // Random bounces with runs around the acceptance threshold.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) a_raw = ~a_raw;
      if ($urandom_range(0, 4) == 0) b_raw = ~b_raw;
      step(1);
    end
    step(3);
    $display("random phase done: checks=%0d errors=%0d", checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
